// File: rtl/imm_extend_pipe.sv
// Immediate extraction/extension stage with a valid/ready handshake.
// One output register plus one skid entry; in_ready comes straight from a flop.
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_Z     = 3'b101,
    FMT_SHAMT = 3'b110,
    FMT_UNDEF = 3'b111
  } fmt_e;

  logic [31:0]      w_imm32;
  logic             w_sext;
  logic             w_illegal;
  logic [XLEN-1:0]  w_imm;
  logic             w_accept;
  logic             w_out_free;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  // Every format is built as a 32-bit value, then widened signed or unsigned.
  always_comb begin
    w_imm32   = '0;
    w_sext    = 1'b1;
    w_illegal = 1'b0;
    case (fmt_e'(in_immsrc))
      FMT_I:     w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:     w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:     w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
      FMT_J:     w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
      FMT_U:     w_imm32 = {in_instr[31:12], 12'b0};
      FMT_Z: begin
        w_imm32 = {27'b0, in_instr[19:15]};
        w_sext  = 1'b0;
      end
      FMT_SHAMT: begin
        w_imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
        w_sext  = 1'b0;
      end
      default: begin
        w_imm32   = '0;
        w_sext    = 1'b0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_imm      = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);
  assign w_accept   = in_valid && r_in_ready && !flush;
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_tag    <= '0;
      r_out_ill    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_tag   <= '0;
      r_skid_ill   <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cnt        <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_out_free) begin
        r_in_ready <= 1'b1;
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_imm    <= r_skid_imm;
          r_out_tag    <= r_skid_tag;
          r_out_ill    <= r_skid_ill;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_imm   <= w_imm;
          r_out_tag   <= in_tag;
          r_out_ill   <= w_illegal;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        // Output is stalled: park the new result in the skid entry.
        r_skid_valid <= 1'b1;
        r_skid_imm   <= w_imm;
        r_skid_tag   <= in_tag;
        r_skid_ill   <= w_illegal;
        r_in_ready   <= 1'b0;
      end else begin
        r_in_ready <= !r_skid_valid;
      end
      if (w_accept && w_illegal && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_ill;
  assign illegal_cnt = r_cnt;

endmodule
